alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, handshaked successor to the combinational datapath ALU.
- Width is parametrised. Adds a flags register (C, Z, N, V) and a multi-cycle shift-add MUL.
- Sits between the decode/control unit and the register file.
- Operands and opcode are accepted with a valid/ready handshake. The result is returned with a one-cycle out_valid pulse.
- Opcodes are the 8-bit instruction macros from the team's instruction header. A new `MUL` macro is added to that header alongside this block.

Parameters:
- WIDTH, 16: operand/result width; legal range 4..32.
- CNT_W, $clog2(WIDTH+1): width of the MUL iteration counter; derived, do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept; high only in IDLE.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- op  in  8  opcode (instruction macros).
- out_valid  out  1  one-cycle pulse: out and flags were just updated.
- out  out  WIDTH  registered result; holds until the next completed op.
- flags  out  4  registered {C, Z, N, V}.
- overflow  out  1  copy of flags[0] (V), kept for existing consumers.

Behaviour:
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE, out=0, flags=0, out_valid=0, counter=0.
  - Any MUL in progress is discarded; no out_valid is produced for it.
- Handshake:
  - Accept happens at an edge where state==IDLE && in_valid. in_ready = (state==IDLE), purely from state.
  - in1, in2 and op are captured at accept. Input changes after accept are ignored.
- States:
  - IDLE: accept of a non-MUL op → stays IDLE. Result and flags are written at the accept edge, and out_valid=1 for the following cycle. Throughput is 1 op/cycle.
  - IDLE: accept of MUL → BUSY, counter=0, product accumulator cleared.
  - BUSY: one shift-add step per edge, counter+1. The step that takes counter to WIDTH writes out/flags and returns to IDLE. out_valid=1 for the next cycle.
  - MUL latency: result visible WIDTH edges after the accept edge.
- Op semantics (unsigned WIDTH-bit arithmetic):
  - ADD/INC: out = sum mod 2^WIDTH; C = carry-out.
  - SUB/DEC: out = difference mod 2^WIDTH; C = borrow (1 when in1 < subtrahend).
  - XOR/OR/AND: bitwise; C=0, V=0.
  - NOT: bitwise ~in1 (not logical); C=0, V=0.
  - RR: rotate right by 1; C = in1[0]. RL: rotate left by 1; C = in1[WIDTH-1]. V=0 for both.
  - LD: out = in2. LDI: out = in1. Z and N updated; C=0, V=0.
  - MUL: out = low WIDTH bits of in1*in2. V = 1 if the high WIDTH bits are non-zero. C=0.
  - JMP, JMA, CLL, RET, ST, NOP: out and flags unchanged, but out_valid still pulses.
  - RST opcode: out=0, flags=0.
  - Any undefined opcode: out=0, flags=0.
- V for ADD/INC/SUB/DEC is two's-complement signed overflow of the operation.
- For every result-writing op: Z = (out==0), N = out[WIDTH-1].
- Boundaries:
  - INC of all-ones → 0, C=1, Z=1.
  - DEC of 0 → all-ones, C=1, N=1.
  - MUL by 0 completes in the full WIDTH cycles (no early exit).
  - in_valid held during BUSY is not accepted until the IDLE edge after completion.
  - rst and in_valid in the same cycle: reset wins; nothing is accepted.

Test Plan:
- Reset/idle: assert rst 2 cycles mid-traffic → out=0x0000, flags=0, out_valid=0, in_ready=1 on the next cycle.
- Back-to-back ADDs (WIDTH=16): 0x7FFF+0x0001 → out=0x8000, N=1, V=1, C=0. Next cycle, 0xFFFF+0x0001 → out=0x0000, Z=1, C=1, V=0. Two consecutive out_valid pulses.
- MUL: 0x0100*0x0100 → in_ready=0 for 16 cycles, then out=0x0000, V=1, Z=1, one out_valid pulse. Then 0x00FF*0x0002 → out=0x01FE, V=0.
- Rotates/NOT: RR 0x0001 → 0x8000, C=1. RL 0x8000 → 0x0001, C=1. NOT 0x00F0 → 0xFF0F, N=1.
- Hold ops: after a result of 0x1234, issue NOP and JMP → out stays 0x1234, flags unchanged, out_valid pulses each time. Undefined opcode 0xFF → out=0, flags=0.
- Reset mid-MUL: assert rst on BUSY cycle 5 → no out_valid, in_ready=1 next cycle. A following ADD 2+3 → out=0x0005 after one cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a {C,Z,N,V} flags register and a multi-cycle shift-add MUL.
// Opcodes follow the team instruction macros; anything unlisted clears out and flags.
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [7:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             overflow
);
    localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_INC = 8'h03;
    localparam logic [7:0] OP_DEC = 8'h04, OP_XOR = 8'h05, OP_OR  = 8'h06, OP_AND = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08, OP_RR  = 8'h09, OP_RL  = 8'h0A, OP_LD  = 8'h0B;
    localparam logic [7:0] OP_LDI = 8'h0C, OP_ST  = 8'h0D, OP_JMP = 8'h0E, OP_JMA = 8'h0F;
    localparam logic [7:0] OP_CLL = 8'h10, OP_RET = 8'h11, OP_RST = 8'h12, OP_MUL = 8'h13;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [3:0]           flags_q, flags_d;
    logic                 valid_q, valid_d;

    logic [WIDTH-1:0]     opnd, alu_res;
    logic [WIDTH:0]       add_r, sub_r, step;
    logic [2*WIDTH-1:0]   mul_p;
    logic                 add_v, sub_v, alu_c, alu_v, hold, clr;

    assign opnd  = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : in2;
    assign add_r = {1'b0, in1} + {1'b0, opnd};
    assign sub_r = {1'b0, in1} - {1'b0, opnd};
    assign add_v = (in1[WIDTH-1] == opnd[WIDTH-1]) && (add_r[WIDTH-1] != in1[WIDTH-1]);
    assign sub_v = (in1[WIDTH-1] != opnd[WIDTH-1]) && (sub_r[WIDTH-1] != in1[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        hold    = 1'b0;
        clr     = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin alu_res = add_r[WIDTH-1:0]; alu_c = add_r[WIDTH]; alu_v = add_v; end
            OP_SUB, OP_DEC: begin alu_res = sub_r[WIDTH-1:0]; alu_c = sub_r[WIDTH]; alu_v = sub_v; end
            OP_XOR: alu_res = in1 ^ in2;
            OP_OR:  alu_res = in1 | in2;
            OP_AND: alu_res = in1 & in2;
            OP_NOT: alu_res = ~in1;
            OP_RR:  begin alu_res = {in1[0], in1[WIDTH-1:1]}; alu_c = in1[0]; end
            OP_RL:  begin alu_res = {in1[WIDTH-2:0], in1[WIDTH-1]}; alu_c = in1[WIDTH-1]; end
            OP_LD:  alu_res = in2;
            OP_LDI: alu_res = in1;
            OP_JMP, OP_JMA, OP_CLL, OP_RET, OP_ST, OP_NOP: hold = 1'b1;
            default: clr = 1'b1;
        endcase
    end

    // Shift-add step: add the multiplicand into the high half when the multiplier LSB is set, then shift right.
    assign step  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_p = {step, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        out_d   = out_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (in_valid && op == OP_MUL) begin
                state_d = BUSY;
                cnt_d   = '0;
                acc_d   = {{WIDTH{1'b0}}, in2};
                mcand_d = in1;
            end else if (in_valid) begin
                valid_d = 1'b1;
                out_d   = hold ? out_q : alu_res;
                flags_d = hold ? flags_q : clr ? 4'b0 :
                          {alu_c, alu_res == '0, alu_res[WIDTH-1], alu_v};
            end
        end else begin
            acc_d = mul_p;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d = IDLE;
                valid_d = 1'b1;
                out_d   = mul_p[WIDTH-1:0];
                flags_d = {1'b0, mul_p[WIDTH-1:0] == '0, mul_p[WIDTH-1], |mul_p[2*WIDTH-1:WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out       = out_q;
    assign flags     = flags_q;
    assign overflow  = flags_q[0];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=16; expectations are queued at drive time
// and popped whenever out_valid is seen. Flags are {C,Z,N,V}.
module tb_alu_seq;
    localparam int W = 16;
    localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_INC = 8'h03;
    localparam logic [7:0] OP_DEC = 8'h04, OP_XOR = 8'h05, OP_OR  = 8'h06, OP_AND = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08, OP_RR  = 8'h09, OP_RL  = 8'h0A, OP_LD  = 8'h0B;
    localparam logic [7:0] OP_LDI = 8'h0C, OP_JMP = 8'h0E, OP_RST = 8'h12, OP_MUL = 8'h13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [7:0]   op = '0;
    logic         in_ready, out_valid, overflow;
    logic [W-1:0] out;
    logic [3:0]   flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op),
        .out_valid(out_valid), .out(out), .flags(flags), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: out=%h flags=%b", out, flags);
            end else begin
                mon_e = sb.pop_front();
                if (out !== mon_e.res || flags !== mon_e.fl || overflow !== mon_e.fl[0]) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h flags=%b ovf=%b, expected out=%h flags=%b",
                             mon_e.name, out, flags, overflow, mon_e.res, mon_e.fl);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        in1 = a;
        in2 = b;
    endtask

    task automatic issue(input string name, input logic [7:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef);
        exp_t e;
        drive(o, a, b);
        e.res = er;
        e.fl = ef;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results still pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic count_busy(input string name, input int exp_cycles);
        int k = 0;
        while (in_ready === 1'b0 && k < 40) begin
            k++;
            @(negedge clk);
        end
        n_chk++;
        if (k != exp_cycles) begin
            n_fail++;
            $display("FAIL %s_busy: in_ready low %0d cycles, expected %0d", name, k, exp_cycles);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (out !== '0 || flags !== 4'b0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: out=%h flags=%b ovf=%b ov=%b rdy=%b, expected 0000 0000 0 0 1",
                     out, flags, overflow, out_valid, in_ready);
        end
        issue("add_8000_8000", OP_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1101);
        @(negedge clk);
        rst = 1'b1;
        op = OP_LDI;
        in1 = 16'h5555;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out !== '0 || flags !== 4'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_traffic: out=%h flags=%b ov=%b rdy=%b, expected 0000 0000 0 1",
                     out, flags, out_valid, in_ready);
        end
        drain("reset");
    endtask

    task automatic test_back_to_back();
        issue("add_7fff_1", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
        issue("add_ffff_1", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pulse1: out_valid=%b, expected 1", out_valid);
        end
        idle();
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pulse2: out_valid=%b, expected 1", out_valid);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse_end: out_valid=%b, expected 0", out_valid);
        end
        drain("b2b");
    endtask

    task automatic test_arith();
        issue("inc_ffff", OP_INC, 16'hFFFF, 16'h1234, 16'h0000, 4'b1100);
        issue("dec_0000", OP_DEC, 16'h0000, 16'h1234, 16'hFFFF, 4'b1010);
        issue("sub_5_7", OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 4'b1010);
        issue("sub_8000_1", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
        issue("xor", OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000);
        issue("or", OP_OR, 16'h8001, 16'h0100, 16'h8101, 4'b0010);
        issue("and_zero", OP_AND, 16'h00FF, 16'hFF00, 16'h0000, 4'b0100);
        issue("ld", OP_LD, 16'h1111, 16'hC0DE, 16'hC0DE, 4'b0010);
        idle();
        drain("arith");
    endtask

    task automatic test_rot_not();
        issue("rr_0001", OP_RR, 16'h0001, 16'h0000, 16'h8000, 4'b1010);
        issue("rl_8000", OP_RL, 16'h8000, 16'h0000, 16'h0001, 4'b1000);
        issue("not_00f0", OP_NOT, 16'h00F0, 16'h0000, 16'hFF0F, 4'b0010);
        idle();
        drain("rot_not");
    endtask

    task automatic test_hold();
        issue("ldi_1234", OP_LDI, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
        issue("nop_hold", OP_NOP, 16'hFFFF, 16'hFFFF, 16'h1234, 4'b0000);
        issue("jmp_hold", OP_JMP, 16'h0000, 16'h0000, 16'h1234, 4'b0000);
        issue("inc_ffff2", OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 4'b1100);
        issue("nop_hold_flags", OP_NOP, 16'h0001, 16'h0001, 16'h0000, 4'b1100);
        issue("ldi_9abc", OP_LDI, 16'h9ABC, 16'h0000, 16'h9ABC, 4'b0010);
        issue("undef_ff", 8'hFF, 16'h1234, 16'h5678, 16'h0000, 4'b0000);
        issue("ldi_8000", OP_LDI, 16'h8000, 16'h0000, 16'h8000, 4'b0010);
        issue("rst_op", OP_RST, 16'h1234, 16'h5678, 16'h0000, 4'b0000);
        idle();
        drain("hold");
    endtask

    task automatic test_mul();
        issue("mul_100_100", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0101);
        issue("mul_ff_2", OP_MUL, 16'h00FF, 16'h0002, 16'h01FE, 4'b0000);
        count_busy("mul_100_100", W);
        idle();
        count_busy("mul_ff_2", W);
        issue("mul_by_0", OP_MUL, 16'h1234, 16'h0000, 16'h0000, 4'b0100);
        idle();
        count_busy("mul_by_0", W);
        issue("mul_big", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001);
        idle();
        drain("mul");
    endtask

    task automatic test_reset_mid_mul();
        issue("ldi_abcd", OP_LDI, 16'hABCD, 16'h0000, 16'hABCD, 4'b0010);
        idle();
        drain("pre_mid_mul");
        drive(OP_MUL, 16'h0003, 16'h0003);
        idle();
        repeat (4) @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mul_busy: in_ready=%b, expected 0", in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || flags !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_mul_reset: rdy=%b ov=%b out=%h flags=%b, expected 1 0 0000 0000",
                     in_ready, out_valid, out, flags);
        end
        issue("add_2_3", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
        idle();
        n_chk++;
        if (out_valid !== 1'b1 || out !== 16'h0005) begin
            n_fail++;
            $display("FAIL add_after_reset: ov=%b out=%h, expected 1 0005", out_valid, out);
        end
        repeat (20) @(negedge clk);
        drain("mid_mul");
    endtask

    task automatic test_reset_collision();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        op = OP_LDI;
        in1 = 16'h7777;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_collision: ov=%b out=%h rdy=%b, expected 0 0000 1", out_valid, out, in_ready);
        end
        repeat (3) @(negedge clk);
        drain("collision");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_arith();
        test_rot_not();
        test_hold();
        test_mul();
        test_reset_mid_mul();
        test_reset_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
